// File: rtl/bmp_stream_if.sv
// Byte-stream input and byte-RAM write port of the BMP loader.
// The master side feeds file bytes and observes the writes; the slave side is the loader.
interface bmp_stream_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8
);
  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  RAM_valid;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic [BYTE_WIDTH-1:0] RAM_D;

  modport master (output in_valid, in_data, input in_ready, RAM_valid, RAM_addr, RAM_D);
  modport slave  (input in_valid, in_data, output in_ready, RAM_valid, RAM_addr, RAM_D);
endinterface

// File: rtl/bmp_stream_loader.sv
// Streams a BMP file into byte RAM while parsing its 54-byte header on the fly.
// Define BMP_PIXEL_ONLY_EN to write only pixel bytes, rebased to address 0.
module bmp_stream_loader #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int TOTAL_SIZE = 786486
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  bmp_stream_if.slave bus,
  output logic [31:0] img_width,
  output logic [31:0] img_height,
  output logic [31:0] data_offset,
  output logic [15:0] bpp,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t                state_reg;
  logic [31:0]           idx_reg;
  logic [31:0]           file_size_reg;
  logic [31:0]           width_reg;
  logic [31:0]           height_reg;
  logic [31:0]           offset_reg;
  logic [15:0]           bpp_reg;
  logic                  ram_valid_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [BYTE_WIDTH-1:0] ram_d_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic [7:0]            byte_in;
  logic [1:0]            lane;
  logic                  accept;
  logic [31:0]           file_size_full;
  logic                  bad_magic;
  logic                  bad_size;
  logic                  bad_offset;
  logic                  last_byte;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;

  assign byte_in = bus.in_data[7:0];
  assign accept  = (state_reg == S_LOAD) && bus.in_valid;

  // All four-byte header fields start at an index with idx[1:0]==2, so one lane select serves them all.
  assign lane = idx_reg[1:0] - 2'd2;

  assign file_size_full = {byte_in, file_size_reg[23:0]};
  assign bad_magic = ((idx_reg == 32'd0) && (byte_in != 8'h42)) ||
                     ((idx_reg == 32'd1) && (byte_in != 8'h4D));
  assign bad_size  = (idx_reg == 32'd5) &&
                     ((file_size_full < 32'd54) || (file_size_full > 32'(TOTAL_SIZE)));
  assign last_byte = (idx_reg > 32'd5) && (idx_reg + 32'd1 == file_size_reg);

`ifdef BMP_PIXEL_ONLY_EN
  logic [31:0] offset_full;
  assign offset_full = {byte_in, offset_reg[23:0]};
  assign bad_offset  = (idx_reg == 32'd13) &&
                       ((offset_full < 32'd54) || (offset_full >= file_size_reg));
  // The offset field is only trustworthy once byte 13 has been captured.
  assign write_en    = (idx_reg > 32'd13) && (idx_reg >= offset_reg);
  assign write_addr  = ADDR_WIDTH'(idx_reg - offset_reg);
`else
  assign bad_offset  = 1'b0;
  assign write_en    = 1'b1;
  assign write_addr  = ADDR_WIDTH'(idx_reg);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      file_size_reg <= '0;
      width_reg     <= '0;
      height_reg    <= '0;
      offset_reg    <= '0;
      bpp_reg       <= '0;
      ram_valid_reg <= 1'b0;
      ram_addr_reg  <= '0;
      ram_d_reg     <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      ram_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_reg     <= S_LOAD;
            idx_reg       <= '0;
            file_size_reg <= '0;
            width_reg     <= '0;
            height_reg    <= '0;
            offset_reg    <= '0;
            bpp_reg       <= '0;
            err_reg       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            ram_valid_reg <= write_en;
            ram_addr_reg  <= write_addr;
            ram_d_reg     <= bus.in_data;
            idx_reg       <= idx_reg + 32'd1;
            case (idx_reg)
              32'd2, 32'd3, 32'd4, 32'd5:     file_size_reg[{lane, 3'b000} +: 8] <= byte_in;
              32'd10, 32'd11, 32'd12, 32'd13: offset_reg[{lane, 3'b000} +: 8]    <= byte_in;
              32'd18, 32'd19, 32'd20, 32'd21: width_reg[{lane, 3'b000} +: 8]     <= byte_in;
              32'd22, 32'd23, 32'd24, 32'd25: height_reg[{lane, 3'b000} +: 8]    <= byte_in;
              32'd28, 32'd29:                 bpp_reg[{idx_reg[0], 3'b000} +: 8] <= byte_in;
              default: ;
            endcase
            if (bad_magic || bad_size || bad_offset) begin
              state_reg <= S_ERR;
              err_reg   <= 1'b1;
            end else if (last_byte) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_LOAD);
  assign bus.RAM_valid = ram_valid_reg;
  assign bus.RAM_addr  = ram_addr_reg;
  assign bus.RAM_D     = ram_d_reg;
  assign img_width     = width_reg;
  assign img_height    = height_reg;
  assign data_offset   = offset_reg;
  assign bpp           = bpp_reg;
  assign busy          = (state_reg == S_LOAD);
  assign done          = done_reg;
  assign err           = err_reg;
endmodule

// File: doc/bmp_stream_loader.md
Name: bmp_stream_loader

Overview:
- Upstream feeder for the BMP byte RAM.
- Accepts a BMP file as a valid/ready byte stream and parses the 54-byte BITMAPFILEHEADER/BITMAPINFOHEADER on the fly.
- Exposes width, height, data offset and bit depth, and issues one RAM write per accepted byte (RAM_valid/RAM_addr/RAM_D).
- Stops at the header-declared file size and flags malformed files.

Parameters:
- ADDR_WIDTH, 20, RAM address width; matches the DEFINE.vh value.
- BYTE_WIDTH, 8, data byte width; fixed 8 for header parsing.
- TOTAL_SIZE, 786486, RAM capacity in bytes (512x512x3 + 54).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a load from IDLE, ignored elsewhere
- in_valid  input  1  upstream byte valid
- in_data  input  BYTE_WIDTH  upstream byte, file order
- in_ready  output  1  loader accepts a byte this cycle
- RAM_valid  output  1  write strobe to byte RAM
- RAM_addr  output  ADDR_WIDTH  write address
- RAM_D  output  BYTE_WIDTH  write data
- img_width  output  32  biWidth, little-endian, bytes 18-21
- img_height  output  32  biHeight, bytes 22-25
- data_offset  output  32  bfOffBits, bytes 10-13
- bpp  output  16  biBitCount, bytes 28-29
- busy  output  1  high in LOAD
- done  output  1  one-cycle pulse when the last byte is written
- err  output  1  sticky until rst or next start

Behaviour:
- Reset: state IDLE. Every output is 0, including all header fields and the byte counter idx.
- States:
  - IDLE: on start go to LOAD and clear idx, header fields and err.
  - LOAD: in_ready=1; a byte is accepted when in_valid&in_ready.
  - DONE: single cycle; done=1; return to IDLE.
  - ERR: err=1; in_ready=0; wait for start or rst.
- Accept rule, for each accepted byte at index idx:
  - Next cycle: RAM_valid=1, RAM_addr=idx[ADDR_WIDTH-1:0], RAM_D=byte.
  - Write latency is exactly 1 cycle.
  - RAM_valid=0 in any cycle following a non-accept.
  - idx increments by 1 per accept.
- Header capture: byte k of the fields above lands in bit range [8*(k-base)+7 : 8*(k-base)]. file_size is captured internally from bytes 2-5.
- Checks:
  - idx=0 must be 0x42 and idx=1 must be 0x4D. On mismatch, that byte is still written, then the next state is ERR.
  - At the accept of idx=5: if file_size<54 or file_size>TOTAL_SIZE, go to ERR after the write.
- Termination: at the accept of idx=file_size-1, the write is issued, in_ready drops the same cycle after the accept, and the FSM enters DONE. done is asserted in the cycle the final RAM_valid is high.
- Back-pressure: in_ready is combinational from state only. It is never dependent on in_valid.
- start while in LOAD, DONE or ERR (except ERR restart) is ignored.
- start in ERR: restart as if from IDLE.
- rst mid-load:
  - Next cycle: IDLE with all outputs 0.
  - A pending RAM write is dropped (RAM_valid=0).
- A byte presented with in_valid while in IDLE is not accepted.

Optional Feature:
- Macro: BMP_PIXEL_ONLY_EN.
- Defined:
  - Bytes with idx < data_offset are parsed but not written (RAM_valid=0).
  - Pixel bytes are written at RAM_addr = idx - data_offset, starting at 0.
  - At the accept of idx=13, data_offset<54 or data_offset>=file_size causes ERR.
- Undefined: the entire file, header included, is written at RAM_addr=idx. There is no data_offset check.

Test Plan:
- 2x2 24bpp BMP (file_size 70, offset 54, 8-byte padded rows) streamed with in_valid=1 continuously:
  - 70 writes, addr 0..69, data matches the file byte for byte.
  - img_width=2, img_height=2, bpp=24, data_offset=54.
  - done pulses once with the write of addr 69.
- Same file with in_valid toggling 1/0 every other cycle: identical write sequence, no RAM_valid on idle cycles, idx never skips.
- First byte 0x43:
  - One write (addr 0, 0x43), then err=1, in_ready=0, no further writes.
  - A subsequent start clears err and a good file loads.
- file_size field = TOTAL_SIZE+1: writes for addr 0..5 only, then err=1.
- rst asserted after 30 accepted bytes:
  - Next cycle all outputs 0 and state IDLE.
  - A new start reloads from addr 0.
- With BMP_PIXEL_ONLY_EN, 2x2 file: exactly 16 writes at addr 0..15 with file bytes 54..69. Offset field 40 → err after idx 13.
